// File: rtl/de_pipe_reg_pkg.sv
// Shared exception-code constants, handler address and the D->E bundle type.
package de_pipe_reg_pkg;

  localparam logic [4:0] NoExcCode      = 5'd31;
  localparam logic [4:0] ExcCodeInt     = 5'd0;
  localparam logic [4:0] ExcCodeAdEL    = 5'd4;
  localparam logic [4:0] ExcCodeAdES    = 5'd5;
  localparam logic [4:0] ExcCodeSyscall = 5'd8;
  localparam logic [4:0] ExcCodeRI      = 5'd10;
  localparam logic [4:0] ExcCodeOv      = 5'd12;

  localparam logic [31:0] HandlerAddr = 32'h0000_4180;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [4:0]  exc_code;
    logic        bd;
    logic [4:0]  a3;
    logic        valid;
  } de_bundle_t;

  // A nop that never carries an exception; only PC/BD may be preserved.
  function automatic de_bundle_t bubble_bundle(input logic [31:0] pc, input logic bd);
    de_bundle_t b;
    b          = '0;
    b.pc       = pc;
    b.bd       = bd;
    b.exc_code = NoExcCode;
    return b;
  endfunction

endpackage

// File: rtl/de_pipe_reg_if.sv
// D-stage inputs and E-stage outputs of the decode-to-execute register.
interface de_pipe_reg_if #(
  parameter int unsigned TNEW_W = 2
);
  logic              Req;
  logic              stall;
  logic [31:0]       PC_D;
  logic [31:0]       Instr_D;
  logic [4:0]        ExcCode_D;
  logic              BD_D;
  logic [31:0]       RD1_D;
  logic [31:0]       RD2_D;
  logic [31:0]       EXT_D;
  logic [4:0]        A3_D;
  logic [TNEW_W-1:0] Tnew_D;

  logic [31:0]       PC_E;
  logic [31:0]       Instr_E;
  logic [31:0]       RD1_E;
  logic [31:0]       RD2_E;
  logic [31:0]       EXT_E;
  logic [4:0]        ExcCode_E;
  logic              BD_E;
  logic [4:0]        A3_E;
  logic [TNEW_W-1:0] Tnew_E;
  logic              valid_E;

  modport master (
    output Req, stall, PC_D, Instr_D, ExcCode_D, BD_D, RD1_D, RD2_D, EXT_D, A3_D, Tnew_D,
    input  PC_E, Instr_E, RD1_E, RD2_E, EXT_E, ExcCode_E, BD_E, A3_E, Tnew_E, valid_E
  );

  modport slave (
    input  Req, stall, PC_D, Instr_D, ExcCode_D, BD_D, RD1_D, RD2_D, EXT_D, A3_D, Tnew_D,
    output PC_E, Instr_E, RD1_E, RD2_E, EXT_E, ExcCode_E, BD_E, A3_E, Tnew_E, valid_E
  );
endinterface

// File: rtl/tnew_age.sv
// Saturating decrement of a Tnew field by one pipeline stage.
module tnew_age #(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0] tnew_cur,
  output logic [Width-1:0] tnew_next
);

  always_comb begin
    tnew_next = '0;
    if (tnew_cur != '0) tnew_next = tnew_cur - Width'(1);
  end

endmodule

// File: rtl/de_pipe_reg.sv
// Decode-to-execute pipeline register with stall bubbles and exception flush.
// Build option: DE_BUBBLE_KEEP_PC_EN keeps PC_D/BD_D in stall bubbles for EPC accuracy.
module de_pipe_reg
  import de_pipe_reg_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HandlerAddr,
  parameter int unsigned TNEW_W     = 2
) (
  input logic         clk,
  input logic         reset,
  de_pipe_reg_if.slave de
);

  de_bundle_t        d_bundle, e_d, e_q;
  logic [TNEW_W-1:0] tnew_aged, tnew_d, tnew_q;

  tnew_age #(
    .Width(TNEW_W)
  ) u_tnew_age (
    .tnew_cur (de.Tnew_D),
    .tnew_next(tnew_aged)
  );

  always_comb begin
    d_bundle          = '0;
    d_bundle.pc       = de.PC_D;
    d_bundle.instr    = de.Instr_D;
    d_bundle.rd1      = de.RD1_D;
    d_bundle.rd2      = de.RD2_D;
    d_bundle.ext      = de.EXT_D;
    d_bundle.exc_code = de.ExcCode_D;
    d_bundle.bd       = de.BD_D;
    d_bundle.a3       = de.A3_D;
    d_bundle.valid    = 1'b1;
  end

  always_comb begin
    e_d    = d_bundle;
    tnew_d = tnew_aged;
    if (de.Req) begin
      e_d    = bubble_bundle(HANDLER_PC, 1'b0);
      tnew_d = '0;
    end else if (de.stall) begin
`ifdef DE_BUBBLE_KEEP_PC_EN
      e_d    = bubble_bundle(de.PC_D, de.BD_D);
`else
      e_d    = bubble_bundle(32'h0, 1'b0);
`endif
      tnew_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= bubble_bundle(32'h0, 1'b0);
      tnew_q <= '0;
    end else begin
      e_q    <= e_d;
      tnew_q <= tnew_d;
    end
  end

  assign de.PC_E      = e_q.pc;
  assign de.Instr_E   = e_q.instr;
  assign de.RD1_E     = e_q.rd1;
  assign de.RD2_E     = e_q.rd2;
  assign de.EXT_E     = e_q.ext;
  assign de.ExcCode_E = e_q.exc_code;
  assign de.BD_E      = e_q.bd;
  assign de.A3_E      = e_q.a3;
  assign de.Tnew_E    = tnew_q;
  assign de.valid_E   = e_q.valid;

endmodule
